// File: rtl/segm7_axi_pkg.sv
// ---------------------------------------------------------------------------
// segm7_axi_pkg
// Shared constants for the 7-segment AXI4-Lite slave front end:
//   - AXI response codes
//   - write / read FSM state encodings
//   - register byte offsets of the display core
// ---------------------------------------------------------------------------
package segm7_axi_pkg;

    // AXI4-Lite response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write FSM
    localparam logic [1:0] W_IDLE   = 2'd0;
    localparam logic [1:0] W_STROBE = 2'd1;
    localparam logic [1:0] W_RESP   = 2'd2;

    // Read FSM
    localparam logic [1:0] R_IDLE   = 2'd0;
    localparam logic [1:0] R_STROBE = 2'd1;
    localparam logic [1:0] R_DATA   = 2'd2;

    // Core register byte offsets
    localparam logic [15:0] REG_DISP_DATA = 16'h0000;
    localparam logic [15:0] REG_CTRL      = 16'h0004;
    localparam logic [15:0] REG_BRIGHT    = 16'h0008;
    localparam logic [15:0] REG_STATUS    = 16'h000C;

endpackage

// File: rtl/segm7_addr_decode.sv
// ---------------------------------------------------------------------------
// segm7_addr_decode
// Combinational decode of a byte address into a "register exists" flag.
// An address is valid when it is word aligned and its word index is below
// NUM_REGS.
//   i_addr  : byte address
//   o_valid : 1 when the address hits an implemented register
// ---------------------------------------------------------------------------
module segm7_addr_decode #(
    parameter int ADDR_W   = 16,
    parameter int NUM_REGS = 4
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_valid
);

    // One extra bit so NUM_REGS itself is representable in the compare.
    localparam logic [ADDR_W-2:0] N_LIM = (ADDR_W-1)'(NUM_REGS);

    logic [ADDR_W-2:0] w_idx;

    assign w_idx   = {1'b0, i_addr[ADDR_W-1:2]};
    assign o_valid = (i_addr[1:0] == 2'b00) && (w_idx < N_LIM);

endmodule

// File: rtl/segm7_axi_slave.sv
// ---------------------------------------------------------------------------
// segm7_axi_slave
// AXI4-Lite slave front end for the 7-segment display core. Terminates all
// five AXI channels and turns each accepted transaction into a one-cycle
// strobe toward the core register file.
//   S_AXI_ACLK / S_AXI_ARSTN : clock, async active-low reset
//   S_AXI_AW* / S_AXI_W*     : write address / data channels
//   S_AXI_B*                 : write response channel
//   S_AXI_AR* / S_AXI_R*     : read address / data channels
//   REG_WREN/WADDR/WDATA/WSTRB : write strobe + latched write payload
//   REG_RDEN/RADDR           : read strobe + latched read address
//   REG_RDATA                : core read data, combinational in REG_RADDR
// Read and write FSMs are independent; each allows one outstanding
// transaction.
// ---------------------------------------------------------------------------
module segm7_axi_slave
    import segm7_axi_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 16,
    parameter int C_NUM_REGS         = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARSTN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            REG_WREN,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   REG_WADDR,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   REG_WDATA,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0] REG_WSTRB,
    output logic                            REG_RDEN,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   REG_RADDR,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   REG_RDATA
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;

    // Goes high on the first edge after reset release; holds all READYs
    // low until then so they never rise combinationally with the reset.
    logic              r_live;

    logic [1:0]        r_wstate;
    logic              r_aw_got;
    logic              r_w_got;
    logic [AW-1:0]     r_waddr;
    logic [DW-1:0]     r_wdata;
    logic [DW/8-1:0]   r_wstrb;
    logic [1:0]        r_bresp;

    logic [1:0]        r_rstate;
    logic [AW-1:0]     r_raddr;
    logic [DW-1:0]     r_rdata;
    logic [1:0]        r_rresp;

    logic              w_waddr_ok;
    logic              w_raddr_ok;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_aw_done;
    logic              w_w_done;
    logic              w_ar_hs;

    segm7_addr_decode #(.ADDR_W(AW), .NUM_REGS(C_NUM_REGS)) u_wdec (
        .i_addr  (r_waddr),
        .o_valid (w_waddr_ok)
    );

    segm7_addr_decode #(.ADDR_W(AW), .NUM_REGS(C_NUM_REGS)) u_rdec (
        .i_addr  (r_raddr),
        .o_valid (w_raddr_ok)
    );

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARSTN) begin
        if (!S_AXI_ARSTN) r_live <= 1'b0;
        else              r_live <= 1'b1;
    end

    // ---------------- write path ----------------
    // Each of AW and W is accepted once; its READY drops after its own
    // handshake. The edge that completes the later handshake goes straight
    // to W_STROBE, giving one write per 3 cycles at full rate.
    assign S_AXI_AWREADY = r_live && (r_wstate == W_IDLE) && !r_aw_got;
    assign S_AXI_WREADY  = r_live && (r_wstate == W_IDLE) && !r_w_got;
    assign w_aw_hs       = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs        = S_AXI_WVALID  && S_AXI_WREADY;
    assign w_aw_done     = r_aw_got || w_aw_hs;
    assign w_w_done      = r_w_got  || w_w_hs;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARSTN) begin
        if (!S_AXI_ARSTN) begin
            r_wstate <= W_IDLE;
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) r_waddr <= S_AXI_AWADDR;
                    if (w_w_hs) begin
                        r_wdata <= S_AXI_WDATA;
                        r_wstrb <= S_AXI_WSTRB;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_wstate <= W_STROBE;
                        r_aw_got <= 1'b0;
                        r_w_got  <= 1'b0;
                    end else begin
                        r_aw_got <= w_aw_done;
                        r_w_got  <= w_w_done;
                    end
                end
                W_STROBE: begin
                    r_bresp  <= w_waddr_ok ? RESP_OKAY : RESP_SLVERR;
                    r_wstate <= W_RESP;
                end
                W_RESP: begin
                    if (S_AXI_BREADY) r_wstate <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // An all-zero WSTRB is a legal no-op: OKAY response, no core write.
    assign REG_WREN     = (r_wstate == W_STROBE) && w_waddr_ok && (|r_wstrb);
    assign REG_WADDR    = r_waddr;
    assign REG_WDATA    = r_wdata;
    assign REG_WSTRB    = r_wstrb;
    assign S_AXI_BVALID = (r_wstate == W_RESP);
    assign S_AXI_BRESP  = r_bresp;

    // ---------------- read path ----------------
    assign S_AXI_ARREADY = r_live && (r_rstate == R_IDLE);
    assign w_ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARSTN) begin
        if (!S_AXI_ARSTN) begin
            r_rstate <= R_IDLE;
            r_raddr  <= '0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_raddr  <= S_AXI_ARADDR;
                        r_rstate <= R_STROBE;
                    end
                end
                R_STROBE: begin
                    // Core data is combinational in REG_RADDR; capture it here.
                    r_rdata  <= w_raddr_ok ? REG_RDATA : '0;
                    r_rresp  <= w_raddr_ok ? RESP_OKAY : RESP_SLVERR;
                    r_rstate <= R_DATA;
                end
                R_DATA: begin
                    if (S_AXI_RREADY) r_rstate <= R_IDLE;
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // No read strobe for an address the core does not implement.
    assign REG_RDEN     = (r_rstate == R_STROBE) && w_raddr_ok;
    assign REG_RADDR    = r_raddr;
    assign S_AXI_RVALID = (r_rstate == R_DATA);
    assign S_AXI_RDATA  = r_rdata;
    assign S_AXI_RRESP  = r_rresp;

endmodule

// File: tb/tb_segm7_axi_slave.sv
// ---------------------------------------------------------------------------
// tb_segm7_axi_slave
// Directed bench for segm7_axi_slave. A small core model answers REG_RDATA
// from REG_RADDR; strobe pulses are counted on the falling edge.
// ---------------------------------------------------------------------------
module tb_segm7_axi_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [15:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        reg_wren;
    logic [15:0] reg_waddr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic        reg_rden;
    logic [15:0] reg_raddr;
    logic [31:0] reg_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int wren_cnt = 0;
    int rden_cnt = 0;
    int base;

    always #5 clk = ~clk;

    segm7_axi_slave dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARSTN   (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .REG_WREN      (reg_wren),
        .REG_WADDR     (reg_waddr),
        .REG_WDATA     (reg_wdata),
        .REG_WSTRB     (reg_wstrb),
        .REG_RDEN      (reg_rden),
        .REG_RADDR     (reg_raddr),
        .REG_RDATA     (reg_rdata)
    );

    // Core register file model (combinational read).
    always_comb begin
        case (reg_raddr)
            16'h0004: reg_rdata = 32'h0BADBEEF;
            16'h000C: reg_rdata = 32'hCAFEF00D;
            default:  reg_rdata = {16'hDEAD, reg_raddr};
        endcase
    end

    always @(negedge clk) begin
        if (reg_wren === 1'b1) wren_cnt++;
        if (reg_rden === 1'b1) rden_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // AW and W presented together, BREADY held high.
    task automatic write_pair(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                              input logic exp_wren, input logic [1:0] exp_resp, input string tag);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk({tag, ".wren"}, 32'(reg_wren), 32'(exp_wren));
        tick();
        chk({tag, ".bvalid"}, 32'(bvalid), 32'd1);
        chk({tag, ".bresp"}, 32'(bresp), 32'(exp_resp));
        tick();
        chk({tag, ".bdone"}, 32'(bvalid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;

        // ---- reset state ----
        #12;
        chk("rst.awready", 32'(awready), 32'd0);
        chk("rst.wready",  32'(wready),  32'd0);
        chk("rst.arready", 32'(arready), 32'd0);
        chk("rst.valids",  {30'd0, bvalid, rvalid}, 32'd0);
        chk("rst.strobes", {30'd0, reg_wren, reg_rden}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel.awready_before_edge", 32'(awready), 32'd0);
        tick();
        chk("rel.readys", {29'd0, awready, wready, arready}, 32'd7);

        // ---- 1: AW+W together at 0x0 ----
        awaddr = 16'h0000; awvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF;
        wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("w1.wren",   32'(reg_wren), 32'd1);
        chk("w1.wdata",  reg_wdata, 32'h12345678);
        chk("w1.wstrb",  32'(reg_wstrb), 32'hF);
        chk("w1.bvalid_early", 32'(bvalid), 32'd0);
        tick();
        chk("w1.wren_off", 32'(reg_wren), 32'd0);
        chk("w1.bvalid", 32'(bvalid), 32'd1);
        chk("w1.bresp",  32'(bresp), 32'd0);
        tick();
        chk("w1.idle_readys", {30'd0, awready, wready}, 32'd3);
        chk("w1.bvalid_off", 32'(bvalid), 32'd0);
        chk("w1.wren_cnt", 32'(wren_cnt), 32'd1);

        // ---- 2: W first, AW 5 cycles later at 0x4, BREADY low 3 cycles ----
        wdata = 32'hA5A50001; wstrb = 4'h3; wvalid = 1'b1; bready = 1'b0;
        tick();
        wvalid = 1'b0;
        chk("w2.wready_drop", 32'(wready), 32'd0);
        chk("w2.awready_hold", 32'(awready), 32'd1);
        repeat (4) tick();
        chk("w2.no_wren_yet", 32'(wren_cnt), 32'd1);
        awaddr = 16'h0004; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("w2.wren",  32'(reg_wren), 32'd1);
        chk("w2.waddr", 32'(reg_waddr), 32'h4);
        chk("w2.wdata", reg_wdata, 32'hA5A50001);
        chk("w2.wstrb", 32'(reg_wstrb), 32'h3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("w2.bvalid_hold", 32'(bvalid), 32'd1);
            chk("w2.bresp_hold",  32'(bresp),  32'd0);
        end
        bready = 1'b1;
        tick();
        chk("w2.bvalid_off", 32'(bvalid), 32'd0);
        chk("w2.wren_cnt", 32'(wren_cnt), 32'd2);

        // ---- 3: invalid addresses and zero strobe ----
        write_pair(16'h0010, 32'h11111111, 4'hF, 1'b0, 2'b10, "w3.range");
        write_pair(16'h0002, 32'h22222222, 4'hF, 1'b0, 2'b10, "w3.align");
        write_pair(16'h0008, 32'h33333333, 4'h0, 1'b0, 2'b00, "w3.nostrb");
        chk("w3.wren_cnt", 32'(wren_cnt), 32'd2);

        // ---- 4: reads ----
        rready = 1'b1; araddr = 16'h000C; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("r1.rden",  32'(reg_rden), 32'd1);
        chk("r1.raddr", 32'(reg_raddr), 32'hC);
        chk("r1.rvalid_early", 32'(rvalid), 32'd0);
        tick();
        chk("r1.rvalid", 32'(rvalid), 32'd1);
        chk("r1.rdata",  rdata, 32'hCAFEF00D);
        chk("r1.rresp",  32'(rresp), 32'd0);
        tick();
        chk("r1.rvalid_off", 32'(rvalid), 32'd0);
        chk("r1.arready", 32'(arready), 32'd1);
        chk("r1.rden_cnt", 32'(rden_cnt), 32'd1);

        araddr = 16'h0020; arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        chk("r2.no_rden", 32'(reg_rden), 32'd0);
        tick();
        chk("r2.rvalid", 32'(rvalid), 32'd1);
        chk("r2.rdata",  rdata, 32'h0);
        chk("r2.rresp",  32'(rresp), 32'd2);
        tick();
        chk("r2.rvalid_hold", 32'(rvalid), 32'd1);
        chk("r2.rresp_hold",  32'(rresp), 32'd2);
        rready = 1'b1;
        tick();
        chk("r2.rvalid_off", 32'(rvalid), 32'd0);

        // ---- 5: simultaneous write to 0x0 and read of 0x4 ----
        base = wren_cnt;
        awaddr = 16'h0000; awvalid = 1'b1; wdata = 32'h0F0F0F0F; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 16'h0004; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("s.both_strobes", {30'd0, reg_wren, reg_rden}, 32'd3);
        tick();
        chk("s.both_valid", {30'd0, bvalid, rvalid}, 32'd3);
        chk("s.rdata", rdata, 32'h0BADBEEF);
        chk("s.resps", {28'd0, bresp, rresp}, 32'd0);
        tick();
        chk("s.both_done", {30'd0, bvalid, rvalid}, 32'd0);
        chk("s.wren_cnt", 32'(wren_cnt - base), 32'd1);

        // ---- 6: reset while BVALID is high ----
        awaddr = 16'h0008; awvalid = 1'b1; wdata = 32'h55AA55AA; wstrb = 4'hF;
        wvalid = 1'b1; bready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        chk("x.bvalid_pre", 32'(bvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("x.bvalid_async", 32'(bvalid), 32'd0);
        chk("x.readys_rst", {29'd0, awready, wready, arready}, 32'd0);
        base = wren_cnt;
        tick();
        rst_n = 1'b1;
        #1;
        chk("x.readys_before_edge", {29'd0, awready, wready, arready}, 32'd0);
        tick();
        chk("x.readys_first_edge", {29'd0, awready, wready, arready}, 32'd7);
        chk("x.bvalid_after", 32'(bvalid), 32'd0);
        bready = 1'b1;
        write_pair(16'h0008, 32'h77777777, 4'hF, 1'b1, 2'b00, "x.new");
        chk("x.new_wdata", reg_wdata, 32'h77777777);
        chk("x.wren_cnt", 32'(wren_cnt - base), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
